// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared widths and port-index type for the memory bus arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;
    localparam int ADDR_W         = 17;
    localparam int DATA_W         = 32;
    localparam int BE_W           = 4;
    localparam int DEFAULT_NPORTS = 4;
    localparam int PORT_IDX_W     = $clog2(DEFAULT_NPORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;
endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// rr_picker : round-robin one-hot pick over I/O ports 1..NPORTS-1, from ptr+1
// Revision  : 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NPORTS = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NPORTS-1:0] mask,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NPORTS-1:0] pick,
    output logic              valid
);
    localparam int TW = IDX_W + 1;
    localparam logic [TW-1:0] LAST = TW'(NPORTS - 1);

    logic [TW-1:0] tgt;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        tgt   = '0;
        for (int k = 1; k < NPORTS; k++) begin
            // Candidate ptr+k wraps from NPORTS-1 back to 1, never visiting port 0
            tgt = {1'b0, ptr} + TW'(k);
            if (tgt > LAST)
                tgt = tgt - LAST;
            for (int i = 1; i < NPORTS; i++) begin
                if (!valid && mask[i] && (tgt == TW'(i))) begin
                    pick[i] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : CPU-priority memory arbiter with I/O starvation override
//                   Optional locked sequences with MEM_ARB_LOCK_EN defined.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORTS   = DEFAULT_NPORTS,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NPORTS-1:0]        lock,
`endif
    input  logic [NPORTS*BE_W-1:0]   port_wr_en,
    input  logic [NPORTS*ADDR_W-1:0] port_addr,
    input  logic [NPORTS*DATA_W-1:0] port_wdata,
    output logic [NPORTS-1:0]        gnt,
    output logic [BE_W-1:0]          mem_wr_en,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     busy
);
    localparam int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    if (NPORTS < 2 || MAX_WAIT < 1 || LOCK_MAX < 1) begin : g_param_check
        $error("mem_bus_arbiter: NPORTS>=2, MAX_WAIT>=1, LOCK_MAX>=1 required");
    end

    logic [NPORTS-1:0] next_gnt, starved, io_req, st_pick, io_pick;
    logic              st_valid, io_valid, hold_lock;
    logic [IDX_W-1:0]  rr_ptr, next_idx;

    assign io_req     = {req[NPORTS-1:1], 1'b0};
    assign starved[0] = 1'b0;
    assign busy       = |gnt;

    for (genvar i = 1; i < NPORTS; i++) begin : g_wait
        logic [WAIT_W-1:0] wait_cnt;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                wait_cnt <= '0;
            else if (!req[i] || gnt[i] || next_gnt[i])
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_SAT)
                wait_cnt <= wait_cnt + 1'b1;
        end
        assign starved[i] = (wait_cnt == WAIT_SAT);
    end

    rr_picker #(.NPORTS(NPORTS), .IDX_W(IDX_W)) u_pick_starved (
        .mask (starved),
        .ptr  (rr_ptr),
        .pick (st_pick),
        .valid(st_valid)
    );

    rr_picker #(.NPORTS(NPORTS), .IDX_W(IDX_W)) u_pick_io (
        .mask (io_req),
        .ptr  (rr_ptr),
        .pick (io_pick),
        .valid(io_valid)
    );

    always_comb begin
        next_gnt = '0;
        if (hold_lock)
            next_gnt = gnt;
        else if (st_valid)
            next_gnt = st_pick;
        else if (req[0])
            next_gnt[0] = 1'b1;
        else if (io_valid)
            next_gnt = io_pick;
    end

    always_comb begin
        next_idx = '0;
        for (int i = 0; i < NPORTS; i++)
            if (next_gnt[i]) next_idx = IDX_W'(i);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt    <= '0;
            rr_ptr <= IDX_W'(NPORTS - 1);
        end else begin
            gnt <= next_gnt;
            if (|next_gnt[NPORTS-1:1])
                rr_ptr <= next_idx;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [LCNT_W-1:0] LOCK_LIMIT = LCNT_W'(LOCK_MAX);

    logic [LCNT_W-1:0] lock_cnt;
    logic [IDX_W-1:0]  gnt_idx, blk_idx;
    logic              blk_valid, owner_locked;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NPORTS; i++)
            if (gnt[i]) gnt_idx = IDX_W'(i);
    end

    // A port that exhausted its lock budget stays unlockable until someone else is served
    assign owner_locked = (|(gnt & req & lock)) && !(blk_valid && (blk_idx == gnt_idx));
    assign hold_lock    = owner_locked && (lock_cnt < LOCK_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_cnt  <= '0;
            blk_valid <= 1'b0;
            blk_idx   <= '0;
        end else begin
            if (hold_lock)
                lock_cnt <= lock_cnt + 1'b1;
            else if (|next_gnt)
                lock_cnt <= LCNT_W'(1);
            else
                lock_cnt <= '0;

            if (owner_locked && !hold_lock) begin
                blk_valid <= 1'b1;
                blk_idx   <= gnt_idx;
            end else if (blk_valid && busy && (gnt_idx != blk_idx)) begin
                blk_valid <= 1'b0;
            end
        end
    end
`else
    assign hold_lock = 1'b0;
`endif

    always_comb begin
        mem_wr_en = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt[i]) begin
                mem_wr_en |= port_wr_en[i*BE_W +: BE_W];
                mem_addr  |= port_addr[i*ADDR_W +: ADDR_W];
                mem_wdata |= port_wdata[i*DATA_W +: DATA_W];
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed self-checking bench; lock test with MEM_ARB_LOCK_EN
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int NP = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NP-1:0]        req;
`ifdef MEM_ARB_LOCK_EN
    logic [NP-1:0]        lock;
`endif
    logic [NP*BE_W-1:0]   port_wr_en;
    logic [NP*ADDR_W-1:0] port_addr;
    logic [NP*DATA_W-1:0] port_wdata;
    logic [NP-1:0]        gnt;
    logic [BE_W-1:0]      mem_wr_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 busy;

    bit [31:0] mem [0:255];
    int vectors     = 0;
    int miscompares = 0;

    mem_bus_arbiter #(.NPORTS(NP), .MAX_WAIT(8), .LOCK_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
`ifdef MEM_ARB_LOCK_EN
        .lock      (lock),
`endif
        .port_wr_en(port_wr_en),
        .port_addr (port_addr),
        .port_wdata(port_wdata),
        .gnt       (gnt),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Byte-lane memory, committing whatever the arbiter presents at each posedge
    always @(posedge clock) begin
        for (int b = 0; b < BE_W; b++)
            if (mem_wr_en[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    task automatic set_port(input int p, input logic [3:0] be, input logic [16:0] a,
                            input logic [31:0] d);
        port_wr_en[p*BE_W +: BE_W]     = be;
        port_addr[p*ADDR_W +: ADDR_W]  = a;
        port_wdata[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
`ifdef MEM_ARB_LOCK_EN
        lock  = '0;
`endif
        for (int p = 0; p < NP; p++) set_port(p, 4'hF, 17'h1FFFF, 32'hFFFF_FFFF);
        repeat (2) @(negedge clock);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (mem_wr_en !== 4'h0) begin miscompares++; $display("FAIL reset_wr_en: got %h expected 0", mem_wr_en); end
        vectors++; if (mem_addr !== 17'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
        for (int p = 0; p < NP; p++) set_port(p, 4'h0, 17'h0, 32'h0);
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp;
        set_port(1, 4'h0, 17'h00001, 32'h0);
        set_port(2, 4'h0, 17'h00002, 32'h0);
        set_port(3, 4'h3, 17'h00010, 32'hDEAD_BEEF);
        req = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            exp = NP'(1 << (1 + i % 3));
            vectors++; if (gnt !== exp) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp); end
            if (i == 2) begin
                vectors++; if (mem_wr_en !== 4'h3) begin miscompares++; $display("FAIL rr_wr_en: got %h expected 3", mem_wr_en); end
                vectors++; if (mem_addr !== 17'h00010) begin miscompares++; $display("FAIL rr_addr: got %h expected 00010", mem_addr); end
            end
            if (i == 3) begin
                vectors++; if (mem[8'h10] !== 32'h0000_BEEF) begin miscompares++; $display("FAIL rr_byte_write: got %h expected 0000beef", mem[8'h10]); end
            end
        end
        req = '0;
        set_port(3, 4'h0, 17'h0, 32'h0);
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_cpu_only();
        int acc = 0;
        set_port(0, 4'h0, 17'h00005, 32'h0);
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (gnt === 4'b0001 && busy === 1'b1 && mem_addr === 17'h00005) acc++;
        end
        req = '0;
        vectors++; if (acc !== 10) begin miscompares++; $display("FAIL cpu_accesses: got %0d expected 10", acc); end
        @(negedge clock);
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL cpu_release: got %b expected 0000", gnt); end
    endtask

    task automatic test_starvation();
        int first = 0;
        req = 4'b0001;
        @(negedge clock);
        req[1] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (gnt[1] === 1'b1) begin
                first  = c;
                req[1] = 1'b0;
                break;
            end
        end
        vectors++; if (first !== 9) begin miscompares++; $display("FAIL starve_latency: got %0d expected 9", first); end
        @(negedge clock);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL starve_cpu_back: got %b expected 0001", gnt); end
        req = '0;
        @(negedge clock);
    endtask

    task automatic test_pulse();
        int seen2 = 0;
        req = 4'b0010;
        @(negedge clock);
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL pulse_p1: got %b expected 0010", gnt); end
        set_port(2, 4'hF, 17'h00020, 32'hCAFE_F00D);
        req = 4'b0101;
        @(negedge clock);
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL pulse_cpu: got %b expected 0001", gnt); end
        req = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (gnt[2] !== 1'b0 || mem_wr_en !== 4'h0) seen2++;
        end
        vectors++; if (seen2 !== 0) begin miscompares++; $display("FAIL pulse_no_gnt2: got %0d cycles expected 0", seen2); end
        vectors++; if (mem[8'h20] !== 32'h0) begin miscompares++; $display("FAIL pulse_no_write: got %h expected 0", mem[8'h20]); end
    endtask

    task automatic test_reset_mid_grant();
        set_port(2, 4'hF, 17'h00030, 32'h55AA_55AA);
        req = 4'b0100;
        @(negedge clock);
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL midrst_gnt2: got %b expected 0100", gnt); end
        reset = 1'b1;
        req   = 4'b0110;
        #1;
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL midrst_gnt: got %b expected 0000", gnt); end
        vectors++; if (mem_wr_en !== 4'h0) begin miscompares++; $display("FAIL midrst_wr_en: got %h expected 0", mem_wr_en); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL midrst_first: got %b expected 0010", gnt); end
        vectors++; if (mem[8'h30] !== 32'h0) begin miscompares++; $display("FAIL midrst_word: got %h expected 0", mem[8'h30]); end
        req = '0;
        set_port(2, 4'h0, 17'h0, 32'h0);
        @(negedge clock);
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        logic [NP-1:0] exp;
        req  = 4'b0010;
        lock = 4'b0010;
        @(negedge clock);
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL lock_start: got %b expected 0010", gnt); end
        req[0] = 1'b1;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clock);
            exp = (c <= 4) ? 4'b0010 : 4'b0001;
            vectors++; if (gnt !== exp) begin miscompares++; $display("FAIL lock_cycle[%0d]: got %b expected %b", c, gnt, exp); end
        end
        req  = '0;
        lock = '0;
        @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_cpu_only();
        test_starvation();
        test_pulse();
        test_reset_mid_grant();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule

`default_nettype wire
